fs_serial_sub: RTL and testbench

Parametrised bit-serial full subtractor: computes D = X − Y − Bin for WIDTH-bit operands, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake frames each operation. Trades the area of a WIDTH-bit ripple subtractor for WIDTH cycles of latency, for arithmetic paths that are not throughput-critical.

---
 rtl/fs_serial_sub_if.sv | 23 ++
 rtl/fs_serial_sub.sv | 127 ++++++++++++
 tb/tb_fs_serial_sub.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fs_serial_sub_if.sv
// Start/busy/done handshake and operand/result bus for fs_serial_sub.
// The overflow flag V exists only when FS_SERIAL_OVF_EN is defined.
interface fs_serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef FS_SERIAL_OVF_EN
  logic             V;

  modport master (output start, X, Y, Bin, input busy, done, D, Bout, V);
  modport slave  (input start, X, Y, Bin, output busy, done, D, Bout, V);
`else
  modport master (output start, X, Y, Bin, input busy, done, D, Bout);
  modport slave  (input start, X, Y, Bin, output busy, done, D, Bout);
`endif
endinterface

// File: rtl/fs_serial_sub.sv
// Bit-serial full subtractor D = X - Y - Bin, LSB first, one bit per clock.
// Define FS_SERIAL_OVF_EN to add the signed overflow flag V.
module fs_serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fs_serial_sub_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] y_sh_q, y_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             xm_q, xm_d;
  logic             ym_q, ym_d;
  logic             v_q, v_d;
  logic             d_bit_c;
  logic             b_next_c;
  logic [WIDTH-1:0] res_next_c;

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    d_bit_c    = x_sh_q[0] ^ y_sh_q[0] ^ brw_q;
    b_next_c   = (~x_sh_q[0] & y_sh_q[0]) | (brw_q & (~x_sh_q[0] | y_sh_q[0]));
    res_next_c = {d_bit_c, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_sh_d  = bus.X;
          y_sh_d  = bus.Y;
          brw_d   = bus.Bin;
          xm_d    = bus.X[WIDTH-1];
          ym_d    = bus.Y[WIDTH-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_sh_d = x_sh_q >> 1;
        y_sh_d = y_sh_q >> 1;
        res_d  = res_next_c;
        brw_d  = b_next_c;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish result; the operand MSBs were captured at accept.
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = res_next_c;
          bout_d  = b_next_c;
          v_d     = (xm_q ^ ym_q) & (xm_q ^ d_bit_c);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      v_q     <= v_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
`ifdef FS_SERIAL_OVF_EN
  assign bus.V    = v_q;
`else
  logic unused_ovf_c;
  assign unused_ovf_c = v_q;
`endif
endmodule

// File: tb/tb_fs_serial_sub.sv
// Directed self-checking bench for fs_serial_sub at WIDTH=8.
// Overflow checks are compiled in when FS_SERIAL_OVF_EN is defined.
module tb_fs_serial_sub;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fs_serial_sub_if #(.WIDTH(W)) bus ();

  fs_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE and waits (bounded) for done; lat=99 on timeout.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                        output int lat);
    bus.X = x; bus.Y = y; bus.Bin = bin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) lat = 99;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.X = '0; bus.Y = '0; bus.Bin = 1'b0;
    #12;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.D !== 8'h00) begin bad++; $display("FAIL reset_D got=%h exp=00", bus.D); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL reset_Bout got=%b exp=0", bus.Bout); end
`ifdef FS_SERIAL_OVF_EN
    total++; if (bus.V !== 1'b0) begin bad++; $display("FAIL reset_V got=%b exp=0", bus.V); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int busy_hi;
    bus.X = 8'h5A; bus.Y = 8'h3C; bus.Bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_hi = 0;
    for (int i = 1; i <= 8; i++) begin
      if (bus.busy === 1'b1) busy_hi++;
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_early_done edge=%0d got=%b exp=0", i, bus.done); end
      tick();
    end
    total++; if (busy_hi != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", busy_hi); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", bus.busy); end
    total++; if (bus.D !== 8'h1E) begin bad++; $display("FAIL basic_D got=%h exp=1e", bus.D); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL basic_Bout got=%b exp=0", bus.Bout); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_underflow();
    int lat;
    launch(8'h00, 8'h01, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL uf1_latency got=%0d exp=8", lat); end
    total++; if (bus.D !== 8'hFF) begin bad++; $display("FAIL uf1_D got=%h exp=ff", bus.D); end
    total++; if (bus.Bout !== 1'b1) begin bad++; $display("FAIL uf1_Bout got=%b exp=1", bus.Bout); end
    tick();
    launch(8'h10, 8'h10, 1'b1, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL uf2_latency got=%0d exp=8", lat); end
    total++; if (bus.D !== 8'hFF) begin bad++; $display("FAIL uf2_D got=%h exp=ff", bus.D); end
    total++; if (bus.Bout !== 1'b1) begin bad++; $display("FAIL uf2_Bout got=%b exp=1", bus.Bout); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    bus.X = 8'h33; bus.Y = 8'h11; bus.Bin = 1'b0; bus.start = 1'b1;
    tick();
    // Keep start high with new operands while busy; must be ignored.
    bus.X = 8'hFF; bus.Y = 8'h00; bus.Bin = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.start = 1'b0;
    n = 3;
    while (bus.done !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != 8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=8", n); end
    total++; if (bus.D !== 8'h22) begin bad++; $display("FAIL b2b_first_D got=%h exp=22", bus.D); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL b2b_first_Bout got=%b exp=0", bus.Bout); end
    bus.X = 8'h05; bus.Y = 8'h03; bus.Bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_accept_done got=%b exp=0", bus.done); end
    for (int i = 0; i < 7; i++) tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_second_early got=%b exp=0", bus.done); end
    tick();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b exp=1", bus.done); end
    total++; if (bus.D !== 8'h02) begin bad++; $display("FAIL b2b_second_D got=%h exp=02", bus.D); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL b2b_second_Bout got=%b exp=0", bus.Bout); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    bus.X = 8'h44; bus.Y = 8'h11; bus.Bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.D !== 8'h00) begin bad++; $display("FAIL mid_rst_D got=%h exp=00", bus.D); end
    total++; if (bus.Bout !== 1'b0) begin bad++; $display("FAIL mid_rst_Bout got=%b exp=0", bus.Bout); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=0", seen); end
    launch(8'h20, 8'h01, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL mid_rst_next_latency got=%0d exp=8", lat); end
    total++; if (bus.D !== 8'h1F) begin bad++; $display("FAIL mid_rst_next_D got=%h exp=1f", bus.D); end
  endtask

  task automatic test_hold();
    int drift;
    drift = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.D !== 8'h1F || bus.Bout !== 1'b0 || bus.done !== 1'b0) drift++;
    end
    total++; if (drift != 0) begin bad++; $display("FAIL hold_stable got=%0d exp=0 D=%h", drift, bus.D); end
  endtask

`ifdef FS_SERIAL_OVF_EN
  task automatic test_ovf();
    int lat;
    launch(8'h80, 8'h01, 1'b0, lat);
    total++; if (bus.D !== 8'h7F) begin bad++; $display("FAIL ovf1_D got=%h exp=7f", bus.D); end
    total++; if (bus.V !== 1'b1) begin bad++; $display("FAIL ovf1_V got=%b exp=1", bus.V); end
    tick();
    launch(8'h7F, 8'hFF, 1'b0, lat);
    total++; if (bus.D !== 8'h80) begin bad++; $display("FAIL ovf2_D got=%h exp=80", bus.D); end
    total++; if (bus.V !== 1'b1) begin bad++; $display("FAIL ovf2_V got=%b exp=1", bus.V); end
    total++; if (bus.Bout !== 1'b1) begin bad++; $display("FAIL ovf2_Bout got=%b exp=1", bus.Bout); end
    tick();
    launch(8'h05, 8'h03, 1'b0, lat);
    total++; if (bus.D !== 8'h02) begin bad++; $display("FAIL ovf3_D got=%h exp=02", bus.D); end
    total++; if (bus.V !== 1'b0) begin bad++; $display("FAIL ovf3_V got=%b exp=0", bus.V); end
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_hold();
`ifdef FS_SERIAL_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
